// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator with a valid/ready
// request/response front end and a per-cycle timeout.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_wdata_i,

    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,

    output logic        cyc_o,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int unsigned CW = (CNT_W == 0) ? 1 : CNT_W;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic          timeout;

    assign timeout = TO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        we_d         = we_q;
        sel_d        = sel_q;
        dat_d        = dat_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    adr_d   = req_addr_i;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    dat_d   = req_wdata_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // err wins over ack; ack wins over a coincident timeout
                if (err_i) begin
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else if (ack_i) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? 32'h0 : dat_i;
                end else if (timeout) begin
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end

                if (err_i || ack_i || timeout) begin
                    cyc_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                cyc_d        = 1'b0;
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            adr_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            dat_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            dat_q        <= dat_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign adr_o        = adr_q;
    assign we_o         = we_q;
    assign sel_o        = sel_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: two instances (default timeout and timeout 4)
// checked each cycle against a transaction-level model.
module tb_wb_initiator;

    logic clk = 1'b0;
    logic rst_n;

    logic        req_valid[2], req_ready[2], req_we[2];
    logic        resp_valid[2], resp_ready[2], resp_err[2];
    logic        cyc[2], stb[2], we[2], ack[2], err[2];
    logic [31:0] req_addr[2], req_wdata[2], resp_rdata[2];
    logic [31:0] adr[2], dato[2], dati[2];
    logic [3:0]  req_sel[2], sel[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_initiator u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_we_i(req_we[0]),
        .req_sel_i(req_sel[0]), .req_wdata_i(req_wdata[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]),
        .cyc_o(cyc[0]), .stb_o(stb[0]), .adr_o(adr[0]), .we_o(we[0]),
        .sel_o(sel[0]), .dat_o(dato[0]), .dat_i(dati[0]),
        .ack_i(ack[0]), .err_i(err[0])
    );

    wb_initiator #(.TIMEOUT_CYCLES(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_we_i(req_we[1]),
        .req_sel_i(req_sel[1]), .req_wdata_i(req_wdata[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]),
        .cyc_o(cyc[1]), .stb_o(stb[1]), .adr_o(adr[1]), .we_o(we[1]),
        .sel_o(sel[1]), .dat_o(dato[1]), .dat_i(dati[1]),
        .ack_i(ack[1]), .err_i(err[1])
    );

    function automatic int to_of(int i);
        return (i == 0) ? 255 : 4;
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] at %0t: got %h, want %h",
                         nm, i, $time, act, exp);
        end
    endtask

    // Transaction model: life of one request is
    // waiting -> strobed for some cycles -> response held -> waiting.
    int          ph[2];
    int          m_high[2];
    logic [31:0] m_adr[2], m_dat[2], m_rdata[2];
    logic        m_we[2], m_err[2];
    logic [3:0]  m_sel[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] <= 0; m_high[i] <= 0;
                m_adr[i] <= 0; m_dat[i] <= 0; m_we[i] <= 0; m_sel[i] <= 0;
                m_rdata[i] <= 0; m_err[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ph[i] == 0) begin
                    if (req_valid[i]) begin
                        ph[i] <= 1; m_high[i] <= 0;
                        m_adr[i] <= req_addr[i]; m_we[i] <= req_we[i];
                        m_sel[i] <= req_sel[i]; m_dat[i] <= req_wdata[i];
                    end
                end else if (ph[i] == 1) begin
                    if (err[i]) begin
                        ph[i] <= 2; m_err[i] <= 1; m_rdata[i] <= 0;
                    end else if (ack[i]) begin
                        ph[i] <= 2; m_err[i] <= 0;
                        m_rdata[i] <= m_we[i] ? 32'h0 : dati[i];
                    end else if (to_of(i) != 0 && m_high[i] + 1 == to_of(i)) begin
                        ph[i] <= 2; m_err[i] <= 1; m_rdata[i] <= 0;
                    end else begin
                        m_high[i] <= m_high[i] + 1;
                    end
                end else if (resp_ready[i]) begin
                    ph[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n) chk("req_ready", i, 32'(req_ready[i]), 32'(ph[i] == 0));
            chk("cyc", i, 32'(cyc[i]), 32'(ph[i] == 1));
            chk("stb", i, 32'(stb[i]), 32'(ph[i] == 1));
            chk("adr", i, adr[i], m_adr[i]);
            chk("we", i, 32'(we[i]), 32'(m_we[i]));
            chk("sel", i, 32'(sel[i]), 32'(m_sel[i]));
            chk("dat_o", i, dato[i], m_dat[i]);
            chk("resp_valid", i, 32'(resp_valid[i]), 32'(ph[i] == 2));
            if (ph[i] == 2) begin
                chk("resp_err", i, 32'(resp_err[i]), 32'(m_err[i]));
                chk("resp_rdata", i, resp_rdata[i], m_rdata[i]);
            end
        end
    end

    // Slave: terminates after sl_wait extra cycles; -1 means silent.
    // sl_kind 0 = ack, 1 = err, 2 = ack and err together.
    bit          rand_mode = 0;
    int          sl_wait[2], sl_kind[2], sl_cnt[2];
    logic [31:0] sl_data[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (stb[i]) begin
                ack[i]  = (sl_cnt[i] == sl_wait[i]) && sl_kind[i] != 1;
                err[i]  = (sl_cnt[i] == sl_wait[i]) && sl_kind[i] != 0;
                dati[i] = (sl_cnt[i] == sl_wait[i]) ? sl_data[i] : $urandom;
                sl_cnt[i]++;
            end else begin
                sl_cnt[i] = 0;
                dati[i]   = $urandom;
                if (rand_mode) begin
                    if (i == 0)
                        sl_wait[i] = ($urandom % 50 == 0) ? -1 : int'($urandom_range(0, 5));
                    else
                        sl_wait[i] = int'($urandom_range(0, 6)) - 1;
                    sl_kind[i] = ($urandom % 6 == 0) ? 1 : (($urandom % 10 == 0) ? 2 : 0);
                    sl_data[i] = $urandom;
                    ack[i] = ($urandom % 8 == 0);
                    err[i] = ($urandom % 16 == 0);
                end else begin
                    ack[i] = 0;
                    err[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rand_mode) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i]  = $urandom % 2;
                req_addr[i]   = $urandom;
                req_we[i]     = $urandom % 2;
                req_sel[i]    = 4'($urandom);
                req_wdata[i]  = $urandom;
                resp_ready[i] = ($urandom % 3 != 0);
            end
        end
    end

    int hcnt[2], slen[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (stb[i]) hcnt[i]++;
            else if (hcnt[i] != 0) begin
                slen[i] = hcnt[i];
                hcnt[i] = 0;
            end
        end
    end

    task automatic do_txn(input int i, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input int wt, input int kind,
                          input logic [31:0] d, input int rd, input bit hold,
                          output int len, output logic re,
                          output logic [31:0] rdat, output int vcnt,
                          output logic cwe, output logic [31:0] cdat);
        bit seen = 0;
        @(negedge clk);
        sl_wait[i] = wt; sl_kind[i] = kind; sl_data[i] = d;
        req_addr[i] = a; req_we[i] = w; req_sel[i] = 4'hF; req_wdata[i] = wd;
        req_valid[i] = 1; resp_ready[i] = (rd == 0);
        vcnt = 0; re = 0; rdat = 0;
        @(negedge clk);
        cwe = we[i]; cdat = dato[i];
        req_valid[i] = hold;
        for (int k = 0; k < 400; k++) begin
            if (resp_valid[i]) begin
                seen = 1; vcnt++;
                re = resp_err[i]; rdat = resp_rdata[i];
                if (vcnt > rd) resp_ready[i] = 1;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
        req_valid[i] = 0;
        if (!seen) chk("resp_arrived", i, 0, 1);
        len = slen[i];
    endtask

    int          len, vc, acc;
    logic        re, cwe;
    logic [31:0] rdat, cdat;

    initial begin
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_addr[i] = 0; req_we[i] = 0; req_sel[i] = 0;
            req_wdata[i] = 0; resp_ready[i] = 0; ack[i] = 0; err[i] = 0;
            dati[i] = 0; sl_wait[i] = -1; sl_kind[i] = 0; sl_cnt[i] = 0;
            sl_data[i] = 0; hcnt[i] = 0; slen[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_req_ready", 0, 32'(req_ready[0]), 1);
        chk("rst_cyc", 0, 32'(cyc[0]), 0);
        chk("rst_adr", 0, adr[0], 0);
        chk("rst_resp_valid", 0, 32'(resp_valid[0]), 0);

        // Write with two wait states.
        do_txn(0, 32'h0200_4000, 1, 32'h0000_1234, 2, 0, 32'hDEAD_BEEF, 0, 0,
               len, re, rdat, vc, cwe, cdat);
        chk("wr_stb_len", 0, 32'(len), 3);
        chk("wr_we", 0, 32'(cwe), 1);
        chk("wr_dat_o", 0, cdat, 32'h0000_1234);
        chk("wr_err", 0, 32'(re), 0);
        chk("wr_rdata", 0, rdat, 0);

        // Zero-wait read.
        do_txn(0, 32'h0200_BFF8, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 0,
               len, re, rdat, vc, cwe, cdat);
        chk("rd_stb_len", 0, 32'(len), 1);
        chk("rd_rdata", 0, rdat, 32'hCAFE_F00D);
        chk("rd_err", 0, 32'(re), 0);

        // Back-to-back reads: one accept every third cycle.
        @(negedge clk);
        sl_wait[0] = 0; sl_kind[0] = 0; sl_data[0] = 32'hCAFE_F00D;
        req_addr[0] = 32'h0200_BFF8; req_we[0] = 0;
        req_valid[0] = 1; resp_ready[0] = 1;
        acc = req_ready[0] ? 1 : 0;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
        end
        @(negedge clk);
        req_valid[0] = 0;
        chk("b2b_accepts", 0, 32'(acc), 3);
        repeat (4) @(negedge clk);

        // err and ack together.
        do_txn(0, 32'h0000_0010, 0, 0, 1, 2, 32'h5555_AAAA, 0, 0,
               len, re, rdat, vc, cwe, cdat);
        chk("errack_err", 0, 32'(re), 1);
        chk("errack_rdata", 0, rdat, 0);

        // Timeout of 4 with a silent slave, then ack on the 4th cycle.
        do_txn(1, 32'h0000_0020, 0, 0, -1, 0, 32'h1111_2222, 0, 0,
               len, re, rdat, vc, cwe, cdat);
        chk("to_stb_len", 1, 32'(len), 4);
        chk("to_err", 1, 32'(re), 1);
        chk("to_rdata", 1, rdat, 0);
        do_txn(1, 32'h0000_0024, 0, 0, 3, 0, 32'h3333_4444, 0, 0,
               len, re, rdat, vc, cwe, cdat);
        chk("ack4_stb_len", 1, 32'(len), 4);
        chk("ack4_err", 1, 32'(re), 0);
        chk("ack4_rdata", 1, rdat, 32'h3333_4444);

        // Response stalled for 10 cycles with a new request waiting.
        do_txn(0, 32'h0000_0030, 0, 0, 1, 0, 32'h7777_8888, 10, 1,
               len, re, rdat, vc, cwe, cdat);
        chk("stall_valid_cycles", 0, 32'(vc), 11);
        chk("stall_rdata", 0, rdat, 32'h7777_8888);

        // Reset in the middle of a bus wait state.
        @(negedge clk);
        sl_wait[0] = -1; req_addr[0] = 32'h0000_0040; req_we[0] = 0;
        req_valid[0] = 1; resp_ready[0] = 1;
        @(negedge clk);
        req_valid[0] = 0;
        repeat (3) @(negedge clk);
        chk("pre_rst_stb", 0, 32'(stb[0]), 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_cyc", 0, 32'(cyc[0]), 0);
        chk("mid_rst_stb", 0, 32'(stb[0]), 0);
        chk("mid_rst_resp_valid", 0, 32'(resp_valid[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (resp_valid[0]) acc++;
        end
        chk("post_rst_no_resp", 0, 32'(acc), 0);
        do_txn(0, 32'h0200_BFF8, 0, 0, 1, 0, 32'h0BAD_F00D, 0, 0,
               len, re, rdat, vc, cwe, cdat);
        chk("post_rst_rdata", 0, rdat, 32'h0BAD_F00D);
        chk("post_rst_err", 0, 32'(re), 0);

        rand_mode = 1;
        repeat (4000) @(negedge clk);
        rand_mode = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
